// File: rtl/lfsr_pkg.sv
// lfsr_pkg: PRBS polynomial constants, checker FSM states, default checker thresholds and saturating add.
package lfsr_pkg;
  localparam int PRBS7_DEGREE = 7;
  localparam logic [6:0] PRBS7 = 7'h60;
  localparam logic [14:0] PRBS15 = 15'h6000;
  localparam logic [22:0] PRBS23 = 23'h42_0000;
  localparam logic [30:0] PRBS31 = 31'h4800_0000;
  localparam int DEF_LOCK_COUNT = 16;
  localparam int DEF_WINDOW = 64;
  localparam int DEF_ERR_THRESH = 4;
  typedef enum logic [1:0] {IDLE, SEARCH, LOCKED} chk_state_e;
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? '1 : s[31:0];
  endfunction
endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois: right-shifting Galois LFSR stepped OUTPUT_WIDTH bits per call, LSB first.
// Ports: state/next_state = LFSR register value before/after the step; data_in = received bits;
// data_out = predicted bits XOR data_in (the error vector). Tap bit i-1 holds the x^i coefficient.
// CHK_NOT_GEN=1 feeds received bits back (self-synchronising checker); 0 feeds predictions (generator).
module lfsr_galois import lfsr_pkg::*; #(
  parameter int POLY_DEGREE = PRBS7_DEGREE,
  parameter logic [POLY_DEGREE-1:0] POLYNOMIAL = PRBS7,
  parameter int OUTPUT_WIDTH = 8,
  parameter bit CHK_NOT_GEN = 1'b0
) (
  input  logic [POLY_DEGREE-1:0]  state,
  input  logic [OUTPUT_WIDTH-1:0] data_in,
  output logic [POLY_DEGREE-1:0]  next_state,
  output logic [OUTPUT_WIDTH-1:0] data_out
);
  always_comb begin
    logic [POLY_DEGREE-1:0] s;
    logic fb;
    s = state;
    fb = 1'b0;
    data_out = '0;
    for (int i = 0; i < OUTPUT_WIDTH; i++) begin
      data_out[i] = s[0] ^ data_in[i];
      fb = CHK_NOT_GEN ? data_in[i] : s[0];
      s = (s >> 1) ^ ({POLY_DEGREE{fb}} & POLYNOMIAL);
    end
    next_state = s;
  end
endmodule

// File: rtl/prbs_check_ctrl.sv
// prbs_check_ctrl: PRBS checker with search/lock FSM, windowed loss-of-lock and saturating error counters.
// Ports: clk, rst (async, active high); enable; clr (sync counter clear); s_valid/s_data (beat, LSB first);
// locked; err_beat (errored-beat pulse while locked); beat_cnt, err_beat_cnt, bit_err_cnt (locked-only counts).
module prbs_check_ctrl import lfsr_pkg::*; #(
  parameter int POLY_DEGREE = PRBS7_DEGREE,
  parameter logic [POLY_DEGREE:1] POLYNOMIAL = PRBS7,
  parameter int DATA_WIDTH = 8,
  parameter int LOCK_COUNT = DEF_LOCK_COUNT,
  parameter int WINDOW = DEF_WINDOW,
  parameter int ERR_THRESH = DEF_ERR_THRESH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clr,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  locked,
  output logic                  err_beat,
  output logic [31:0]           beat_cnt,
  output logic [31:0]           err_beat_cnt,
  output logic [31:0]           bit_err_cnt
);
  localparam int CW = $clog2(LOCK_COUNT + 1);
  localparam int WW = $clog2(WINDOW + 1);
  localparam int EW = $clog2(ERR_THRESH + 1);
  localparam int PW = $clog2(DATA_WIDTH + 1);
  chk_state_e state_q, state_d;
  logic [POLY_DEGREE-1:0] lfsr_state_q, lfsr_state_d, chk_next, gen_next;
  logic [DATA_WIDTH-1:0] chk_err, gen_err;
  logic [CW-1:0] clean_cnt_q, clean_cnt_d;
  logic [WW-1:0] win_cnt_q, win_cnt_d;
  logic [EW-1:0] win_err_q, win_err_d;
  logic locked_q, locked_d, err_beat_q, err_beat_d;
  logic [31:0] beat_cnt_q, beat_cnt_d, err_beat_cnt_q, err_beat_cnt_d, bit_err_cnt_q, bit_err_cnt_d;
  function automatic logic [PW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < DATA_WIDTH; i++) popcount = popcount + PW'(v[i]);
  endfunction
  lfsr_galois #(.POLY_DEGREE(POLY_DEGREE), .POLYNOMIAL(POLYNOMIAL), .OUTPUT_WIDTH(DATA_WIDTH), .CHK_NOT_GEN(1'b1)) u_chk (
    .state(lfsr_state_q), .data_in(s_data), .next_state(chk_next), .data_out(chk_err)
  );
  lfsr_galois #(.POLY_DEGREE(POLY_DEGREE), .POLYNOMIAL(POLYNOMIAL), .OUTPUT_WIDTH(DATA_WIDTH), .CHK_NOT_GEN(1'b0)) u_gen (
    .state(lfsr_state_q), .data_in(s_data), .next_state(gen_next), .data_out(gen_err)
  );
  always_comb begin
    state_d = state_q;
    lfsr_state_d = lfsr_state_q;
    clean_cnt_d = clean_cnt_q;
    win_cnt_d = win_cnt_q;
    win_err_d = win_err_q;
    err_beat_d = 1'b0;
    beat_cnt_d = beat_cnt_q;
    err_beat_cnt_d = err_beat_cnt_q;
    bit_err_cnt_d = bit_err_cnt_q;
    if (!enable) begin
      state_d = IDLE;
      clean_cnt_d = '0;
      win_cnt_d = '0;
      win_err_d = '0;
    end else if (state_q == IDLE) begin
      state_d = SEARCH;
    end else if (s_valid && state_q == SEARCH) begin
      lfsr_state_d = chk_next;
      clean_cnt_d = |chk_err ? '0 : clean_cnt_q + 1'b1;
      if (!(|chk_err) && clean_cnt_q == CW'(LOCK_COUNT - 1)) begin
        state_d = LOCKED;
        clean_cnt_d = '0;
        win_cnt_d = '0;
        win_err_d = '0;
      end
    end else if (s_valid) begin
      lfsr_state_d = gen_next;
      err_beat_d = |gen_err;
      beat_cnt_d = sat_add(beat_cnt_q, 32'd1);
      err_beat_cnt_d = err_beat_d ? sat_add(err_beat_cnt_q, 32'd1) : err_beat_cnt_q;
      bit_err_cnt_d = sat_add(bit_err_cnt_q, 32'(popcount(gen_err)));
      win_cnt_d = win_cnt_q == WW'(WINDOW - 1) ? '0 : win_cnt_q + 1'b1;
      win_err_d = win_cnt_q == WW'(WINDOW - 1) ? '0 : win_err_q + EW'(err_beat_d);
      // threshold check last so loss of lock wins over a window wrap on the same beat
      if (err_beat_d && win_err_q == EW'(ERR_THRESH - 1)) begin
        state_d = SEARCH;
        win_cnt_d = '0;
        win_err_d = '0;
      end
    end
    if (clr) begin
      beat_cnt_d = '0;
      err_beat_cnt_d = '0;
      bit_err_cnt_d = '0;
    end
    locked_d = state_d == LOCKED;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lfsr_state_q <= '1;
      clean_cnt_q <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      locked_q <= 1'b0;
      err_beat_q <= 1'b0;
      beat_cnt_q <= '0;
      err_beat_cnt_q <= '0;
      bit_err_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_state_q <= lfsr_state_d;
      clean_cnt_q <= clean_cnt_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      locked_q <= locked_d;
      err_beat_q <= err_beat_d;
      beat_cnt_q <= beat_cnt_d;
      err_beat_cnt_q <= err_beat_cnt_d;
      bit_err_cnt_q <= bit_err_cnt_d;
    end
  end
  assign locked = locked_q;
  assign err_beat = err_beat_q;
  assign beat_cnt = beat_cnt_q;
  assign err_beat_cnt = err_beat_cnt_q;
  assign bit_err_cnt = bit_err_cnt_q;
endmodule
